cp0_status_stack: RTL and testbench

CP0_STATUS_STACK -- requirements
Module: cp0_status_stack

---
 rtl/cp0_status_stack.sv | 134 +++++++++++++
 tb/tb_cp0_status_stack.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cp0_status_stack.sv
// CP0 Status register with a nested exception-context stack and interrupt pending logic.
// Each exception pushes {KSU, EXL, IE} and each ERET pops it. An exception taken
// while the stack is full sets a sticky overflow flag.
module cp0_status_stack #(
    parameter int unsigned NUM_IRQ      = 8,
    parameter int unsigned STACK_DEPTH  = 4,
    parameter logic [31:0] RESET_STATUS = 32'h000000E0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               writeenable,
    input  logic                               activeexception,
    input  logic                               eret,
    input  logic [31:0]                        writedata,
    input  logic [NUM_IRQ-1:0]                 irq,
    output logic [31:0]                        status,
    output logic                               iec,
    output logic                               exl,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_overflow,
    output logic                               irq_pending,
    output logic [2:0]                         irq_id
);

    localparam int unsigned DW    = $clog2(STACK_DEPTH + 1);
    localparam int unsigned AW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned IM_LO = 8;
    localparam int unsigned IM_HI = IM_LO + NUM_IRQ - 1;

    logic [31:0]        status_q, status_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               push;
    logic [3:0]         ctx_cur;
    logic [3:0]         ctx_top;
    logic [3:0]         stack_q [STACK_DEPTH];
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;
    logic [NUM_IRQ-1:0] pend;

    // Current context and the entry on top of the stack
    always_comb begin
        ctx_cur = {status_q[4:3], status_q[1], status_q[0]};
        ctx_top = stack_q[AW'(depth_q - DW'(1))];
    end

    // Next-state: exception beats eret, and eret beats the MTC0 write
    always_comb begin
        status_d = status_q;
        depth_d  = depth_q;
        ovf_d    = ovf_q;
        push     = 1'b0;
        if (activeexception) begin
            if (depth_q < DW'(STACK_DEPTH)) begin
                push    = 1'b1;
                depth_d = depth_q + DW'(1);
            end else begin
                ovf_d = 1'b1;
            end
            status_d[4:3] = 2'b00;
            status_d[1]   = 1'b1;
            status_d[0]   = 1'b0;
        end else if (eret) begin
            if (depth_q != '0) begin
                status_d[4:3] = ctx_top[3:2];
                status_d[1]   = ctx_top[1];
                status_d[0]   = ctx_top[0];
                depth_d       = depth_q - DW'(1);
            end else begin
                // Empty stack: leave exception level with interrupts enabled
                status_d[1] = 1'b0;
                status_d[0] = 1'b1;
            end
        end else if (writeenable) begin
            status_d = writedata;
        end
    end

    // Status, depth and sticky overflow registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= RESET_STATUS;
            depth_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            depth_q  <= depth_d;
            ovf_q    <= ovf_d;
        end
    end

    // Context stack storage; cleared on reset so stale contexts never reappear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= 4'b0000;
            end
        end else if (push) begin
            stack_q[AW'(depth_q)] <= ctx_cur;
        end
    end

    // Two-flop synchronizer for the asynchronous interrupt lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
        end
    end

    // Masked pending lines and highest-numbered pending index
    always_comb begin
        pend   = sync2_q & status_q[IM_HI:IM_LO];
        irq_id = 3'd0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (pend[i]) begin
                irq_id = 3'(i);
            end
        end
    end

    // Output assignments
    always_comb begin
        status         = status_q;
        iec            = status_q[0];
        exl            = status_q[1];
        depth          = depth_q;
        stack_overflow = ovf_q;
        irq_pending    = (|pend) & status_q[0] & ~status_q[1];
    end

endmodule

// File: tb/tb_cp0_status_stack.sv
// Directed self-checking bench for cp0_status_stack (default depth and a depth-2 instance).
module tb_cp0_status_stack;

    logic        clk;
    logic        reset;
    logic        writeenable, activeexception, eret;
    logic [31:0] writedata;
    logic [7:0]  irq;
    logic [31:0] status;
    logic        iec, exl;
    logic [2:0]  depth;
    logic        stack_overflow, irq_pending;
    logic [2:0]  irq_id;

    logic        we2, ae2, eret2;
    logic [31:0] wd2;
    logic [7:0]  irq2;
    logic [31:0] status2;
    logic        iec2, exl2;
    logic [1:0]  depth2;
    logic        ovf2, pend2;
    logic [2:0]  id2;

    int tests;
    int fails;

    cp0_status_stack dut (
        .clk(clk), .reset(reset), .writeenable(writeenable),
        .activeexception(activeexception), .eret(eret), .writedata(writedata),
        .irq(irq), .status(status), .iec(iec), .exl(exl), .depth(depth),
        .stack_overflow(stack_overflow), .irq_pending(irq_pending), .irq_id(irq_id)
    );

    cp0_status_stack #(.STACK_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .writeenable(we2),
        .activeexception(ae2), .eret(eret2), .writedata(wd2),
        .irq(irq2), .status(status2), .iec(iec2), .exl(exl2), .depth(depth2),
        .stack_overflow(ovf2), .irq_pending(pend2), .irq_id(id2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        writeenable = 0; activeexception = 0; eret = 0;
        we2 = 0; ae2 = 0; eret2 = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle(); writedata = 0; irq = 0; wd2 = 0; irq2 = 0;
        #1;
        tests++; if (status !== 32'h000000E0) begin fails++; $display("FAIL reset_status got %h exp %h", status, 32'h000000E0); end
        tests++; if (depth !== 3'd0) begin fails++; $display("FAIL reset_depth got %0d exp 0", depth); end
        tests++; if ({stack_overflow, irq_pending, irq_id, iec, exl} !== 7'b0) begin fails++; $display("FAIL reset_flags got %b exp 0", {stack_overflow, irq_pending, irq_id, iec, exl}); end
        repeat (2) tick();
        reset = 0;
    endtask

    task automatic test_mtc0_irq();
        writeenable = 1; writedata = 32'h0000FF01; irq = 8'h10;
        tick();
        writeenable = 0;
        tests++; if (status !== 32'h0000FF01) begin fails++; $display("FAIL mtc0_status got %h exp %h", status, 32'h0000FF01); end
        tests++; if (irq_pending !== 1'b0) begin fails++; $display("FAIL sync_latency got %b exp 0", irq_pending); end
        tick();
        tests++; if (irq_pending !== 1'b1) begin fails++; $display("FAIL irq_pending got %b exp 1", irq_pending); end
        tests++; if (irq_id !== 3'd4) begin fails++; $display("FAIL irq_id4 got %0d exp 4", irq_id); end
        irq = 8'h00;
    endtask

    task automatic test_nesting();
        logic [2:0] exp_d [6];
        exp_d[0] = 1; exp_d[1] = 2; exp_d[2] = 3; exp_d[3] = 2; exp_d[4] = 1; exp_d[5] = 0;
        writeenable = 1; writedata = 32'h0000FF11;
        tick();
        writeenable = 0;
        for (int i = 0; i < 6; i++) begin
            activeexception = (i < 3); eret = (i >= 3);
            tick();
            tests++; if (depth !== exp_d[i]) begin fails++; $display("FAIL nest_depth step %0d got %0d exp %0d", i, depth, exp_d[i]); end
        end
        idle();
        tests++; if (status[4:0] !== 5'b10001) begin fails++; $display("FAIL nest_restore got %b exp 10001", status[4:0]); end
        tests++; if (status !== 32'h0000FF11) begin fails++; $display("FAIL nest_upper got %h exp %h", status, 32'h0000FF11); end
    endtask

    task automatic test_priority();
        activeexception = 1; eret = 1; writeenable = 1; writedata = 32'hFFFFFFFF;
        tick();
        idle();
        tests++; if (status !== 32'h0000FF02) begin fails++; $display("FAIL prio_status got %h exp %h", status, 32'h0000FF02); end
        tests++; if (depth !== 3'd1) begin fails++; $display("FAIL prio_depth got %0d exp 1", depth); end
        eret = 1;
        tick();
        idle();
        tests++; if (status !== 32'h0000FF11 || depth !== 3'd0) begin fails++; $display("FAIL prio_pop got %h/%0d exp 0000ff11/0", status, depth); end
    endtask

    task automatic test_eret_empty();
        writeenable = 1; writedata = 32'h0000FF02;
        tick();
        writeenable = 0; eret = 1;
        tick();
        idle();
        tests++; if (status !== 32'h0000FF01 || depth !== 3'd0) begin fails++; $display("FAIL eret_empty got %h/%0d exp 0000ff01/0", status, depth); end
    endtask

    task automatic test_irq_id();
        irq = 8'h81; writeenable = 1; writedata = 32'h00000101;
        tick();
        writeenable = 0;
        tick();
        tests++; if (irq_id !== 3'd0 || irq_pending !== 1'b1) begin fails++; $display("FAIL irq_id0 got %0d/%b exp 0/1", irq_id, irq_pending); end
        writeenable = 1; writedata = 32'h00008101;
        tick();
        tests++; if (irq_id !== 3'd7) begin fails++; $display("FAIL irq_id7 got %0d exp 7", irq_id); end
        writedata = 32'h00008103;
        tick();
        writeenable = 0;
        tests++; if (irq_pending !== 1'b0 || irq_id !== 3'd7) begin fails++; $display("FAIL irq_exl got %b/%0d exp 0/7", irq_pending, irq_id); end
    endtask

    task automatic test_overflow();
        logic [1:0]  exp_d [6];
        logic [31:0] exp_s [6];
        exp_d[0] = 1; exp_d[1] = 2; exp_d[2] = 2; exp_d[3] = 1; exp_d[4] = 0; exp_d[5] = 0;
        exp_s[0] = 32'hE2; exp_s[1] = 32'hE2; exp_s[2] = 32'hE2;
        exp_s[3] = 32'hE2; exp_s[4] = 32'hE0; exp_s[5] = 32'hE1;
        for (int i = 0; i < 6; i++) begin
            ae2 = (i < 3); eret2 = (i >= 3);
            tick();
            tests++; if (depth2 !== exp_d[i] || status2 !== exp_s[i]) begin fails++; $display("FAIL ovf_step %0d got %0d/%h exp %0d/%h", i, depth2, status2, exp_d[i], exp_s[i]); end
        end
        idle();
        tests++; if (ovf2 !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", ovf2); end
        tests++; if (iec2 !== 1'b1 || exl2 !== 1'b0) begin fails++; $display("FAIL ovf_underflow got ie=%b exl=%b exp 1/0", iec2, exl2); end
    endtask

    task automatic test_async_reset();
        writeenable = 1; writedata = 32'h0000FF11;
        tick();
        writeenable = 0; activeexception = 1;
        repeat (3) tick();
        idle();
        tests++; if (depth !== 3'd3) begin fails++; $display("FAIL pre_reset_depth got %0d exp 3", depth); end
        #3 reset = 1;
        #1;
        tests++; if (status !== 32'h000000E0 || depth !== 3'd0) begin fails++; $display("FAIL async_reset got %h/%0d exp 000000e0/0", status, depth); end
        tests++; if ({irq_pending, irq_id, iec, exl, ovf2} !== 7'b0) begin fails++; $display("FAIL async_flags got %b exp 0", {irq_pending, irq_id, iec, exl, ovf2}); end
        #2 reset = 0;
        eret = 1;
        tick();
        idle();
        tests++; if (status !== 32'h000000E1 || depth !== 3'd0) begin fails++; $display("FAIL post_reset_eret got %h/%0d exp 000000e1/0", status, depth); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_mtc0_irq();
        test_nesting();
        test_priority();
        test_eret_empty();
        test_irq_id();
        test_overflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
